difftest_deferred_control: RTL and testbench
============================================

Name: difftest_deferred_control

Overview:
- Deferred-result step controller for the simulation difftest endpoint.
- Forwards per-cycle commit step counts to the C-side checker through non-blocking DPI calls. It does not wait for a result on every step.
- Polls the checker for a verdict only periodically, which amortises DPI round-trip cost.
- Presents the verdict as an 8-bit simv_result code: 0 none, 1 DONE, 2 FAIL. The endpoint uses this code for finish, fatal, perf-dump and workload-switch decisions.

Parameters:
- STEP_WIDTH, default 8: width of step; equals CONFIG_DIFFTEST_STEPWIDTH.
- FETCH_PERIOD, default 4096: number of cycles between result polls; legal range 1..2^32-1.
- PENDING_WIDTH, default 32: width of the pending-step accumulator.

Ports:
- clock, input, 1: sole clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-high; clears all state immediately.
- step, input, STEP_WIDTH: instructions committed this cycle; 0 means no commit.
- simv_result, output, 8: verdict code; 0 none, 1 DONE, 2 FAIL, other nonzero values treated as failure.

Behaviour:
- Reset (async, active-high):
  - Asserting reset forces simv_result=0, cycle_cnt=0, pending=0, res_pending=0, res_value=0 at once, without waiting for a clock edge.
  - No DPI call is made while reset is high.
- DPI imports/exports:
  - import "DPI-C" function void simv_nstep(byte step): non-blocking enqueue of steps to the checker; returns nothing.
  - import "DPI-C" function byte simv_result_fetch(): returns the current verdict (0/1/2/other).
  - export "DPI-C" function void simv_result_set(byte r): C side may push a verdict asynchronously. It sets res_value=r and res_pending=1.
- Step forwarding: every rising edge with reset low and step!=0:
  - call simv_nstep(step) in that edge's always block;
  - pending <= pending + step, saturating at all-ones.
- Polling:
  - cycle_cnt increments every non-reset cycle.
  - When cycle_cnt == FETCH_PERIOD-1: cycle_cnt wraps to 0, and if pending != 0, call simv_result_fetch() and clear pending to 0.
  - The fetched value is registered into simv_result at that same edge: 1-cycle fetch latency, visible the cycle after the poll edge.
  - If pending==0 at the poll edge, no fetch is made.
- Pushed results:
  - A res_pending set by simv_result_set is applied at the next rising edge: simv_result <= res_value, res_pending <= 0.
  - If a poll fetch and a pushed result coincide on one edge, the fetched value wins and res_pending is cleared.
- Result holding:
  - DONE (1) is a single-cycle pulse: the edge after simv_result became 1, it returns to 0 unless a new fetch/push on that edge writes a new value.
  - This gives workload_switch exactly one pulse per completed workload.
  - FAIL (2) and any other nonzero value other than 1 are sticky until reset; later fetches and pushes are ignored.
  - A fetched 0 leaves a 0 result at 0.
- Same-cycle step and poll: the simv_nstep call for that cycle's step is issued before the fetch within the same edge. Pending is evaluated including that step, so a verdict can cover it.
- Reset mid-operation: accumulated pending and unfetched results are discarded. Checker-side queued steps are the C side's responsibility.
- Without DPI (synthesis stub): simv_result is tied to 0. Not required beyond elaborating cleanly.

Test Plan (C stub model records nstep calls and returns a programmable verdict):
- Reset, then FETCH_PERIOD=8 with step=0 for 32 cycles -> no simv_nstep and no fetch calls; simv_result stays 0.
- step=3 at cycle 2, step=5 at cycle 4, stub verdict 0 -> nstep calls (3) then (5); one fetch at cycle 7; simv_result stays 0.
- step=1 each cycle, stub returns 1 at the first poll -> simv_result=1 for exactly 1 cycle after the poll edge, then 0; the next poll returns 0.
- Stub returns 2 at a poll -> simv_result=2 and remains 2 across later polls returning 0 or 1, until reset.
- C calls simv_result_set(2) mid-period -> simv_result=2 on the next edge with no fetch; an async reset pulse between edges -> simv_result=0 immediately.
- Poll edge coinciding with a pushed value 1 and a fetched value 2 -> simv_result=2 (fetch wins) and the push is discarded.

Source files
------------

// File: rtl/difftest_deferred_control.sv
// difftest_deferred_control: streams commit steps to the checker and
// polls for a verdict every FETCH_PERIOD cycles.
module difftest_deferred_control #(
    parameter int unsigned STEP_WIDTH    = 8,
    parameter int unsigned FETCH_PERIOD  = 4096,
    parameter int unsigned PENDING_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [STEP_WIDTH-1:0] step,
    output logic [7:0]            simv_result
);

`ifdef SYNTHESIS

    assign simv_result = 8'd0;

`else

    localparam logic [31:0] LAST = 32'(FETCH_PERIOD - 1);

    logic [31:0]              cycle_cnt;
    logic [PENDING_WIDTH-1:0] pending;
    logic [PENDING_WIDTH-1:0] pending_acc;
    logic [PENDING_WIDTH:0]   pending_sum;
    logic                     wrap;
    logic                     do_fetch;
    logic                     res_pending;
    logic                     sticky;

    // Pushes arrive from the C side between edges; a sequence count
    // against a registered ack turns them into a one-shot request.
    byte unsigned res_value;
    int unsigned  push_seq;
    int unsigned  ack_seq;

    // Behavioural checker stand-in for DPI-less simulation.
    byte unsigned stub_verdict;
    int unsigned  nstep_calls;
    int unsigned  nstep_sum;
    int unsigned  fetch_calls;

    function automatic void simv_nstep(input byte s);
        nstep_calls = nstep_calls + 1;
        nstep_sum   = nstep_sum + 32'(unsigned'(s));
    endfunction

    function automatic byte simv_result_fetch();
        fetch_calls = fetch_calls + 1;
        return byte'(stub_verdict);
    endfunction

    function automatic void simv_stub_verdict(input byte v);
        stub_verdict = v;
    endfunction

    function void simv_result_set(input byte r);
        res_value = r;
        push_seq  = push_seq + 1;
    endfunction

    // Saturating pending count including this cycle's step.
    always_comb begin
        pending_sum = {1'b0, pending} + (PENDING_WIDTH+1)'(step);
        pending_acc = pending_sum[PENDING_WIDTH]
                    ? '1 : pending_sum[PENDING_WIDTH-1:0];
        wrap        = (cycle_cnt == LAST);
        do_fetch    = wrap && (pending_acc != '0);
        res_pending = (push_seq != ack_seq);
        sticky      = (simv_result != 8'd0) && (simv_result != 8'd1);
    end

    // Step forwarding, periodic poll and verdict register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_cnt   <= '0;
            pending     <= '0;
            simv_result <= 8'd0;
            ack_seq     <= push_seq;
        end else begin
            cycle_cnt <= wrap ? '0 : cycle_cnt + 32'd1;
            pending   <= do_fetch ? '0 : pending_acc;
            ack_seq   <= push_seq;
            if (step != '0)
                simv_nstep(byte'(8'(step)));
            if (do_fetch && sticky)
                void'(simv_result_fetch());
            else if (do_fetch)
                simv_result <= 8'(simv_result_fetch());
            else if (sticky)
                simv_result <= simv_result;
            else if (res_pending)
                simv_result <= res_value;
            else if (simv_result == 8'd1)
                simv_result <= 8'd0;
        end
    end

`endif

endmodule

// File: tb/tb_difftest_deferred_control.sv
// tb_difftest_deferred_control: directed steps against the built-in
// checker stand-in, FETCH_PERIOD=8 and an 8-bit pending counter.
module tb_difftest_deferred_control;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] step  = 8'd0;
    logic [7:0] simv_result;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    difftest_deferred_control #(
        .STEP_WIDTH   (8),
        .FETCH_PERIOD (8),
        .PENDING_WIDTH(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .step       (step),
        .simv_result(simv_result)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input logic [7:0] s);
        step = s;
        @(posedge clock);
        #1;
        step = 8'd0;
    endtask

    task automatic reset_pulse(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_res"}, 32'(simv_result), 0);
        check({tag, "_cnt"}, dut.cycle_cnt, 0);
        check({tag, "_pend"}, 32'(dut.pending), 0);
        reset = 1'b0;
    endtask

    initial begin
        // reset state
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rst_res", 32'(simv_result), 0);
        check("rst_cnt", dut.cycle_cnt, 0);
        check("rst_pend", 32'(dut.pending), 0);
        reset = 1'b0;

        // idle: four polls with nothing pending
        dut.simv_stub_verdict(8'd0);
        repeat (32) tick(8'd0);
        check("idle_nstep", dut.nstep_calls, 0);
        check("idle_fetch", dut.fetch_calls, 0);
        check("idle_res", 32'(simv_result), 0);
        check("idle_cnt", dut.cycle_cnt, 0);

        // steps 3 and 5, poll at cycle 7, verdict 0
        tick(8'd0);
        tick(8'd0);
        tick(8'd3);
        check("s3_calls", dut.nstep_calls, 1);
        check("s3_sum", dut.nstep_sum, 3);
        tick(8'd0);
        tick(8'd5);
        check("s5_calls", dut.nstep_calls, 2);
        check("s5_sum", dut.nstep_sum, 8);
        check("s5_pend", 32'(dut.pending), 8);
        tick(8'd0);
        tick(8'd0);
        check("prepoll_fetch", dut.fetch_calls, 0);
        tick(8'd0);
        check("poll0_fetch", dut.fetch_calls, 1);
        check("poll0_pend", 32'(dut.pending), 0);
        check("poll0_res", 32'(simv_result), 0);

        // DONE pulse
        dut.simv_stub_verdict(8'd1);
        repeat (7) tick(8'd1);
        check("done_pre", 32'(simv_result), 0);
        tick(8'd1);
        check("done_res", 32'(simv_result), 1);
        check("done_fetch", dut.fetch_calls, 2);
        dut.simv_stub_verdict(8'd0);
        tick(8'd1);
        check("done_drop", 32'(simv_result), 0);
        repeat (7) tick(8'd1);
        check("done_next_fetch", dut.fetch_calls, 3);
        check("done_next_res", 32'(simv_result), 0);

        // FAIL is sticky
        dut.simv_stub_verdict(8'd2);
        repeat (8) tick(8'd1);
        check("fail_res", 32'(simv_result), 2);
        check("fail_fetch", dut.fetch_calls, 4);
        dut.simv_stub_verdict(8'd1);
        repeat (8) tick(8'd1);
        check("fail_hold_poll", 32'(simv_result), 2);
        check("fail_hold_fetch", dut.fetch_calls, 5);
        dut.simv_result_set(8'd1);
        tick(8'd1);
        check("fail_hold_push", 32'(simv_result), 2);
        check("fail_pend1", 32'(dut.pending), 1);
        reset_pulse("rst1");

        // pushed FAIL mid-period, no fetch
        tick(8'd0);
        tick(8'd0);
        dut.simv_result_set(8'd2);
        tick(8'd0);
        check("push_res", 32'(simv_result), 2);
        check("push_fetch", dut.fetch_calls, 5);
        reset_pulse("rst2");

        // saturation, then push 1 vs fetched 2 at the poll
        dut.simv_stub_verdict(8'd2);
        tick(8'd200);
        check("sat_200", 32'(dut.pending), 200);
        tick(8'd100);
        check("sat_300", 32'(dut.pending), 255);
        tick(8'd10);
        check("sat_hold", 32'(dut.pending), 255);
        repeat (4) tick(8'd0);
        dut.simv_result_set(8'd1);
        tick(8'd0);
        check("coinA_res", 32'(simv_result), 2);
        check("coinA_fetch", dut.fetch_calls, 6);
        check("coinA_pend", 32'(dut.pending), 0);
        reset_pulse("rst3");

        // push 2 vs fetched 1, step only on the poll edge
        dut.simv_stub_verdict(8'd1);
        repeat (7) tick(8'd0);
        check("coinB_pre", dut.fetch_calls, 6);
        dut.simv_result_set(8'd2);
        tick(8'd4);
        check("coinB_res", 32'(simv_result), 1);
        check("coinB_fetch", dut.fetch_calls, 7);
        tick(8'd0);
        check("coinB_drop", 32'(simv_result), 0);
        check("tot_calls", dut.nstep_calls, 39);
        check("tot_sum", dut.nstep_sum, 355);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
